// File: rtl/hpm_counter_bank_pkg.sv
// Shared definitions for the hardware performance-monitor counter bank:
// CSR geometry, address map, register-kind decode and the response record.
package hpm_counter_bank_pkg;

  localparam int XLEN         = 64;
  localparam int CSR_ADDR_LEN = 12;

  localparam logic [CSR_ADDR_LEN-1:0] HPM_CNT_BASE = 12'hB03;
  localparam logic [CSR_ADDR_LEN-1:0] HPM_EVT_BASE = 12'h323;
  localparam logic [CSR_ADDR_LEN-1:0] HPM_INHIBIT  = 12'h320;
  localparam logic [CSR_ADDR_LEN-1:0] HPM_OVF      = 12'hDA0;
  localparam logic [CSR_ADDR_LEN-1:0] HPM_OVF_EN   = 12'hDA1;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_CNT,
    REG_SEL,
    REG_INHIBIT,
    REG_OVF,
    REG_OVF_EN
  } hpm_reg_e;

  typedef struct packed {
    logic            valid;
    logic            excp;
    logic [XLEN-1:0] rdata;
  } hpm_resp_t;

endpackage

// File: rtl/hpm_counter_bank_counter.sv
// One event counter: a CSR write has priority over the event increment,
// and wrap flags an increment out of all-ones that the write did not override.
module hpm_counter #(
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 wr_en,
  input  logic [CNT_WIDTH-1:0] wr_data,
  output logic [CNT_WIDTH-1:0] value,
  output logic                 wrap
);

  assign wrap = inc && !wr_en && (&value);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (wr_en) begin
      value <= wr_data;
    end else if (inc) begin
      value <= value + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/hpm_counter_bank.sv
// Performance-monitor counter bank: CSR decode, single-entry response register
// with valid/ready handshake, event selection and sticky overflow status.
module hpm_counter_bank
  import hpm_counter_bank_pkg::*;
#(
  parameter int NUM_CNT      = 8,
  parameter int CNT_WIDTH    = 64,
  parameter int EVT_NUM      = 16,
  parameter int EVT_ID_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    csr_req_valid_i,
  output logic                    csr_req_ready_o,
  input  logic [CSR_ADDR_LEN-1:0] csr_addr_i,
  input  logic                    csr_write_i,
  input  logic [XLEN-1:0]         csr_wdata_i,
  output logic                    csr_resp_valid_o,
  input  logic                    csr_resp_ready_i,
  output logic [XLEN-1:0]         csr_rdata_o,
  output logic                    csr_excp_o,
  input  logic [EVT_NUM-1:0]      evt_i,
  output logic                    ovf_irq_o
);

  localparam int SEL_SPAN = 2 ** EVT_ID_WIDTH;
  localparam logic [EVT_ID_WIDTH:0]   EVT_LIMIT = (EVT_ID_WIDTH + 1)'(EVT_NUM);
  localparam logic [CSR_ADDR_LEN-1:0] NUM_CNT_A = CSR_ADDR_LEN'(NUM_CNT);

  // Handshake: a request is taken when valid && ready. Ready only drops while a
  // response is being held back by the consumer, so the single response
  // register is never overwritten before it is consumed.
  hpm_resp_t resp;
  logic      accept;
  logic      wr_acc;

  logic [EVT_ID_WIDTH-1:0] sel [NUM_CNT];
  logic [NUM_CNT-1:0]      inhibit;
  logic [NUM_CNT-1:0]      ovf;
  logic [NUM_CNT-1:0]      irq_en;

  logic [CNT_WIDTH-1:0]    cnt_val [NUM_CNT];
  logic [CNT_WIDTH-1:0]    cnt_wdata;
  logic [NUM_CNT-1:0]      cnt_wr;
  logic [NUM_CNT-1:0]      inc;
  logic [NUM_CNT-1:0]      wrap;
  logic [NUM_CNT-1:0]      ovf_clr;
  logic [SEL_SPAN-1:0]     evt_pad;

  logic [CSR_ADDR_LEN-1:0] cnt_off;
  logic [CSR_ADDR_LEN-1:0] sel_off;
  hpm_reg_e                reg_kind;
  logic [XLEN-1:0]         rd_data;
  logic                    unused_wdata;

  assign csr_req_ready_o  = !(resp.valid && !csr_resp_ready_i);
  assign accept           = csr_req_valid_i && csr_req_ready_o;
  assign wr_acc           = accept && csr_write_i;
  assign csr_resp_valid_o = resp.valid;
  assign csr_rdata_o      = resp.rdata;
  assign csr_excp_o       = resp.excp;
  assign cnt_wdata        = csr_wdata_i[CNT_WIDTH-1:0];
  assign unused_wdata     = ^csr_wdata_i;

  assign cnt_off = csr_addr_i - HPM_CNT_BASE;
  assign sel_off = csr_addr_i - HPM_EVT_BASE;

  always_comb begin
    reg_kind = REG_NONE;
    if (cnt_off < NUM_CNT_A)          reg_kind = REG_CNT;
    else if (sel_off < NUM_CNT_A)     reg_kind = REG_SEL;
    else if (csr_addr_i == HPM_INHIBIT) reg_kind = REG_INHIBIT;
    else if (csr_addr_i == HPM_OVF)     reg_kind = REG_OVF;
    else if (csr_addr_i == HPM_OVF_EN)  reg_kind = REG_OVF_EN;
  end

  // Read data is the pre-edge register state, zero-extended; unmapped reads stay 0.
  always_comb begin
    rd_data = '0;
    case (reg_kind)
      REG_CNT: begin
        for (int k = 0; k < NUM_CNT; k++) begin
          if (cnt_off == CSR_ADDR_LEN'(k)) rd_data[CNT_WIDTH-1:0] = cnt_val[k];
        end
      end
      REG_SEL: begin
        for (int k = 0; k < NUM_CNT; k++) begin
          if (sel_off == CSR_ADDR_LEN'(k)) rd_data[EVT_ID_WIDTH-1:0] = sel[k];
        end
      end
      REG_INHIBIT: rd_data[NUM_CNT-1:0] = inhibit;
      REG_OVF:     rd_data[NUM_CNT-1:0] = ovf;
      REG_OVF_EN:  rd_data[NUM_CNT-1:0] = irq_en;
      default:     rd_data = '0;
    endcase
  end

  // Selects beyond the implemented events never count but are still stored.
  always_comb begin
    evt_pad                = '0;
    evt_pad[EVT_NUM-1:0]   = evt_i;
    for (int k = 0; k < NUM_CNT; k++) begin
      inc[k]    = !inhibit[k] && ({1'b0, sel[k]} < EVT_LIMIT) && evt_pad[sel[k]];
      cnt_wr[k] = wr_acc && (reg_kind == REG_CNT) && (cnt_off == CSR_ADDR_LEN'(k));
    end
    ovf_clr = (wr_acc && reg_kind == REG_OVF) ? csr_wdata_i[NUM_CNT-1:0] : '0;
  end

  for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
    hpm_counter #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .inc    (inc[k]),
      .wr_en  (cnt_wr[k]),
      .wr_data(cnt_wdata),
      .value  (cnt_val[k]),
      .wrap   (wrap[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_CNT; k++) sel[k] <= '0;
      inhibit    <= '1;
      ovf        <= '0;
      irq_en     <= '0;
      resp       <= '0;
      ovf_irq_o  <= 1'b0;
    end else begin
      ovf_irq_o <= |(ovf & irq_en);
      // A wrap in the same cycle as its clear keeps the bit set.
      ovf       <= (ovf & ~ovf_clr) | wrap;

      if (wr_acc) begin
        case (reg_kind)
          REG_SEL: begin
            for (int k = 0; k < NUM_CNT; k++) begin
              if (sel_off == CSR_ADDR_LEN'(k)) sel[k] <= csr_wdata_i[EVT_ID_WIDTH-1:0];
            end
          end
          REG_INHIBIT: inhibit <= csr_wdata_i[NUM_CNT-1:0];
          REG_OVF_EN:  irq_en  <= csr_wdata_i[NUM_CNT-1:0];
          default: ;
        endcase
      end

      if (accept) begin
        resp.valid <= 1'b1;
        resp.excp  <= (reg_kind == REG_NONE);
        resp.rdata <= rd_data;
      end else if (csr_resp_ready_i) begin
        resp.valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hpm_counter_bank.sv
// Bench for hpm_counter_bank (NUM_CNT=8, CNT_WIDTH=8): register table, directed
// corner sequences and a randomized run against a cycle-level reference model.
module tb_hpm_counter_bank;

  localparam int NC = 8;
  localparam int CW = 8;
  localparam int EN = 16;
  localparam int EW = 5;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [11:0] addr = '0;
  logic        write = 1'b0;
  logic [63:0] wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [63:0] rdata;
  logic        excp;
  logic [15:0] evt = '0;
  logic        irq;

  always #5 clk = ~clk;

  hpm_counter_bank #(
    .NUM_CNT(NC), .CNT_WIDTH(CW), .EVT_NUM(EN), .EVT_ID_WIDTH(EW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .csr_req_valid_i (req_valid),
    .csr_req_ready_o (req_ready),
    .csr_addr_i      (addr),
    .csr_write_i     (write),
    .csr_wdata_i     (wdata),
    .csr_resp_valid_o(resp_valid),
    .csr_resp_ready_i(resp_ready),
    .csr_rdata_o     (rdata),
    .csr_excp_o      (excp),
    .evt_i           (evt),
    .ovf_irq_o       (irq)
  );

  // ---------------- scoreboard state ----------------
  int n_chk = 0;
  int n_err = 0;

  logic [7:0]  m_cnt [NC];
  logic [4:0]  m_sel [NC];
  logic [7:0]  m_inh, m_ovf, m_en;
  logic        m_valid, m_excp, m_irq;
  logic [63:0] m_rdata;

  typedef struct {
    logic [11:0] addr;
    logic        wr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_excp;
  } vec_t;

  vec_t tbl [21];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < NC; k++) begin
      m_cnt[k] = '0;
      m_sel[k] = '0;
    end
    m_inh = 8'hFF; m_ovf = '0; m_en = '0;
    m_valid = 1'b0; m_excp = 1'b0; m_irq = 1'b0; m_rdata = '0;
  endfunction

  function automatic void model_read(input logic [11:0] a, output logic [63:0] rd, output logic ex);
    int ci = int'(a) - 'hB03;
    int si = int'(a) - 'h323;
    rd = '0;
    ex = 1'b0;
    if (ci >= 0 && ci < NC)   rd = {56'd0, m_cnt[ci]};
    else if (si >= 0 && si < NC) rd = {59'd0, m_sel[si]};
    else if (a == 12'h320)    rd = {56'd0, m_inh};
    else if (a == 12'hDA0)    rd = {56'd0, m_ovf};
    else if (a == 12'hDA1)    rd = {56'd0, m_en};
    else                      ex = 1'b1;
  endfunction

  // One clock of stimulus: inputs are already set; the model predicts the edge.
  task automatic cycle();
    logic        m_ready, acc, ex, is_w;
    logic [63:0] rd;
    logic [7:0]  n_cnt [NC];
    logic [4:0]  n_sel [NC];
    logic [7:0]  n_inh, n_en, n_ovf, wrapped;
    int          ci, si;
    @(negedge clk);
    m_ready = !(m_valid && !resp_ready);
    check("req_ready", 64'(req_ready), 64'(m_ready));
    acc = req_valid && m_ready;
    model_read(addr, rd, ex);
    is_w = acc && write && !ex;
    ci = int'(addr) - 'hB03;
    si = int'(addr) - 'h323;
    n_cnt = m_cnt; n_sel = m_sel; n_inh = m_inh; n_en = m_en; wrapped = '0;
    for (int k = 0; k < NC; k++) begin
      if (is_w && ci == k) begin
        n_cnt[k] = wdata[7:0];
      end else if (!m_inh[k] && int'(m_sel[k]) < EN && evt[m_sel[k][3:0]]) begin
        if (m_cnt[k] == 8'hFF) wrapped[k] = 1'b1;
        n_cnt[k] = m_cnt[k] + 8'd1;
      end
    end
    if (is_w && si >= 0 && si < NC) n_sel[si] = wdata[4:0];
    if (is_w && addr == 12'h320) n_inh = wdata[7:0];
    if (is_w && addr == 12'hDA1) n_en = wdata[7:0];
    n_ovf = m_ovf;
    if (is_w && addr == 12'hDA0) n_ovf = n_ovf & ~wdata[7:0];
    n_ovf = n_ovf | wrapped;
    @(posedge clk);
    m_irq = |(m_ovf & m_en);
    m_cnt = n_cnt; m_sel = n_sel; m_inh = n_inh; m_en = n_en; m_ovf = n_ovf;
    if (acc) begin
      m_valid = 1'b1; m_rdata = rd; m_excp = ex;
    end else if (resp_ready) begin
      m_valid = 1'b0;
    end
    #1;
    check("resp_valid", 64'(resp_valid), 64'(m_valid));
    check("ovf_irq", 64'(irq), 64'(m_irq));
    if (m_valid) begin
      check("rdata", rdata, m_rdata);
      check("excp", 64'(excp), 64'(m_excp));
    end
  endtask

  task automatic req(input logic [11:0] a, input logic w, input logic [63:0] d);
    req_valid = 1'b1; addr = a; write = w; wdata = d;
    cycle();
    req_valid = 1'b0; write = 1'b0;
  endtask

  // Asynchronous reset between clock edges; outputs must clear without a clock.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_rdata", rdata, 64'd0);
    check("rst_excp", 64'(excp), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    model_reset();
    req_valid = 1'b0; write = 1'b0; evt = '0; resp_ready = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    tbl[0]  = '{12'h320, 1'b0, 64'h0,                   64'hFF, 1'b0};
    tbl[1]  = '{12'hDA0, 1'b0, 64'h0,                   64'h00, 1'b0};
    tbl[2]  = '{12'hDA1, 1'b0, 64'h0,                   64'h00, 1'b0};
    tbl[3]  = '{12'hB03, 1'b0, 64'h0,                   64'h00, 1'b0};
    tbl[4]  = '{12'h323, 1'b1, 64'hFFFF_FFFF_FFFF_FF33, 64'h00, 1'b0};
    tbl[5]  = '{12'h323, 1'b0, 64'h0,                   64'h13, 1'b0};
    tbl[6]  = '{12'hB04, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'h00, 1'b0};
    tbl[7]  = '{12'hB04, 1'b0, 64'h0,                   64'hF0, 1'b0};
    tbl[8]  = '{12'hDA1, 1'b1, 64'hFFFF_0F0F,           64'h00, 1'b0};
    tbl[9]  = '{12'hDA1, 1'b0, 64'h0,                   64'h0F, 1'b0};
    tbl[10] = '{12'hB0F, 1'b0, 64'h0,                   64'h00, 1'b1};
    tbl[11] = '{12'hB0B, 1'b1, 64'h5,                   64'h00, 1'b1};
    tbl[12] = '{12'h32B, 1'b0, 64'h0,                   64'h00, 1'b1};
    tbl[13] = '{12'h123, 1'b1, 64'hFFFF,                64'h00, 1'b1};
    tbl[14] = '{12'h320, 1'b1, 64'h1FF,                 64'hFF, 1'b0};
    tbl[15] = '{12'h320, 1'b0, 64'h0,                   64'hFF, 1'b0};
    tbl[16] = '{12'h320, 1'b1, 64'h0,                   64'hFF, 1'b0};
    tbl[17] = '{12'hDA1, 1'b0, 64'h0,                   64'h0F, 1'b0};
    tbl[18] = '{12'h32A, 1'b0, 64'h0,                   64'h00, 1'b0};
    tbl[19] = '{12'hB0A, 1'b0, 64'h0,                   64'h00, 1'b0};
    tbl[20] = '{12'hDA0, 1'b1, 64'hFF,                  64'h00, 1'b0};

    do_reset();

    for (int i = 0; i < 21; i++) begin
      req(tbl[i].addr, tbl[i].wr, tbl[i].wdata);
      check($sformatf("tbl%0d_rdata", i), rdata, tbl[i].exp_rdata);
      check($sformatf("tbl%0d_excp", i), 64'(excp), 64'(tbl[i].exp_excp));
    end

    // Ten events on a selected input.
    do_reset();
    req(12'h320, 1'b1, 64'h0);
    req(12'h323, 1'b1, 64'h2);
    evt = 16'h0004;
    for (int i = 0; i < 10; i++) cycle();
    evt = '0;
    req(12'hB03, 1'b0, 64'h0);
    check("count10", rdata, 64'd10);

    // Wrap, sticky overflow, irq one cycle later, clear.
    req(12'hDA1, 1'b1, 64'h1);
    req(12'hB03, 1'b1, 64'hFE);
    evt = 16'h0004;
    cycle();
    cycle();
    check("irq_not_yet", 64'(irq), 64'd0);
    evt = '0;
    cycle();
    check("irq_set", 64'(irq), 64'd1);
    req(12'hB03, 1'b0, 64'h0);
    check("wrapped_cnt", rdata, 64'd0);
    req(12'hDA0, 1'b0, 64'h0);
    check("ovf_sticky", rdata, 64'd1);
    req(12'hDA0, 1'b1, 64'h1);
    cycle();
    check("irq_cleared", 64'(irq), 64'd0);

    // Counter write colliding with an event.
    evt = 16'h0004;
    cycle();
    req(12'hB03, 1'b1, 64'd100);
    check("wr_old_value", rdata, 64'd1);
    evt = '0;
    req(12'hB03, 1'b0, 64'h0);
    check("wr_wins", rdata, 64'd100);
    req(12'hDA0, 1'b0, 64'h0);
    check("wr_no_ovf", rdata, 64'd0);

    // Back-pressure on the response channel.
    resp_ready = 1'b0;
    req_valid = 1'b1; addr = 12'h320; write = 1'b0;
    cycle();
    addr = 12'hDA1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_ready", 64'(req_ready), 64'd0);
      check("stall_rdata", rdata, 64'd0);
    end
    resp_ready = 1'b1;
    cycle();
    check("release_rdata", rdata, 64'd1);
    req_valid = 1'b0;
    cycle();
    check("release_drain", 64'(resp_valid), 64'd0);

    // Reset while counting with a response pending.
    req(12'hB03, 1'b1, 64'hFF);
    evt = 16'h0004;
    cycle();
    cycle();
    check("pre_rst_irq", 64'(irq), 64'd1);
    resp_ready = 1'b0;
    req_valid = 1'b1; addr = 12'hB03;
    cycle();
    check("pre_rst_valid", 64'(resp_valid), 64'd1);
    do_reset();
    req(12'h320, 1'b0, 64'h0);
    check("post_rst_inhibit", rdata, 64'hFF);
    req(12'hB03, 1'b0, 64'h0);
    check("post_rst_cnt", rdata, 64'd0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      req_valid = ($urandom_range(0, 3) != 0);
      write     = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 6))
        0, 1:    addr = 12'hB03 + 12'($urandom_range(0, 9));
        2:       addr = 12'h323 + 12'($urandom_range(0, 9));
        3:       addr = 12'h320;
        4:       addr = 12'hDA0;
        5:       addr = 12'hDA1;
        default: addr = 12'($urandom);
      endcase
      wdata = {$urandom, $urandom};
      if ($urandom_range(0, 2) == 0) wdata[7:0] = 8'hF0 + 8'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) wdata[4] = 1'b0;
      evt        = 16'($urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    req_valid = 1'b0;
    resp_ready = 1'b1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/hpm_counter_bank.md
HPM_COUNTER_BANK -- requirements
Module: hpm_counter_bank

Interface
REQ-001 SHALL have parameter NUM_CNT, default 8: number of event counters (1..29).
REQ-002 SHALL have parameter CNT_WIDTH, default 64: counter width (1..XLEN).
REQ-003 SHALL have parameter EVT_NUM, default 16: number of event inputs.
REQ-004 SHALL have parameter EVT_ID_WIDTH, default 5: event-select field width; it SHALL satisfy 2^EVT_ID_WIDTH >= EVT_NUM.
REQ-005 SHALL have ports:
  clk  input  1  single clock, rising edge.
  rst  input  1  reset, asynchronous, active-high.
  csr_req_valid_i  input  1  access request valid.
  csr_req_ready_o  output  1  request accepted when valid and ready.
  csr_addr_i  input  CSR_ADDR_LEN  CSR address.
  csr_write_i  input  1  write access (0 = read only).
  csr_wdata_i  input  XLEN  write data.
  csr_resp_valid_o  output  1  response valid.
  csr_resp_ready_i  input  1  response consumed.
  csr_rdata_o  output  XLEN  read data, zero-extended.
  csr_excp_o  output  1  illegal address.
  evt_i  input  EVT_NUM  per-cycle event pulses.
  ovf_irq_o  output  1  overflow interrupt.

Function
REQ-006 Address map:
  - counter k: 12'hB03+k
  - event select k: 12'h323+k
  - inhibit: 12'h320, one bit per counter
  - overflow status: 12'hDA0, write-1-to-clear
  - overflow irq enable: 12'hDA1
REQ-007 Counter k SHALL increment by 1 in a cycle when inhibit[k]==0, sel[k] < EVT_NUM and evt_i[sel[k]]==1.
REQ-008 If sel[k] >= EVT_NUM, counter k SHALL hold; the select value SHALL still be stored and read back.
REQ-009 Wrap-around: an increment from all-ones SHALL produce zero and set ovf[k], which is sticky.
REQ-010 A request is accepted when csr_req_valid_i && csr_req_ready_o.
REQ-011 csr_req_ready_o SHALL be 0 while csr_resp_valid_o==1 && csr_resp_ready_i==0; it SHALL be 1 otherwise.
REQ-012 Latency: csr_resp_valid_o SHALL assert in the cycle after acceptance.
  - It SHALL hold, with stable rdata and excp, until csr_resp_ready_i.
  - Back-to-back accepted requests SHALL give back-to-back responses.
REQ-013 csr_rdata_o SHALL return the register value before the accepted write and before that cycle's increment.
REQ-014 Writes SHALL take effect at the accept edge.
  - Counter writes SHALL be truncated to CNT_WIDTH.
  - Select writes SHALL be truncated to EVT_ID_WIDTH.
  - Inhibit and irq-enable writes SHALL be truncated to NUM_CNT bits.
REQ-015 A counter write and an increment of the same counter in the same cycle: the written value SHALL win, with no increment and no ovf set.
REQ-016 Overflow status write: bits written 1 SHALL clear.
  - If an overflow sets a bit in the same cycle as a clear of that bit, set SHALL win.
REQ-017 An unmapped address, or an index >= NUM_CNT, SHALL give a response with csr_excp_o=1 and rdata=0, and SHALL change no state.
REQ-018 ovf_irq_o SHALL be registered: (|(ovf & irq_en)) of the previous cycle.

Reset
REQ-019 On rst, asynchronously, the block SHALL clear:
  - all counters, selects and ovf to 0
  - inhibit to all-ones
  - irq_en to 0
  - csr_resp_valid_o, csr_rdata_o, csr_excp_o and ovf_irq_o to 0
REQ-020 rst asserted mid-response SHALL drop csr_resp_valid_o at once; the pending response is lost.
  - csr_req_ready_o SHALL be 1 after reset.

Structure
REQ-021 The shared package SHALL hold:
  - address constants HPM_CNT_BASE, HPM_EVT_BASE, HPM_INHIBIT, HPM_OVF, HPM_OVF_EN
  - the response struct
  - uses of CSR_ADDR_LEN and XLEN
REQ-022 One sub-module hpm_counter SHALL be instantiated NUM_CNT times, one per counter.
  - Inputs: inc, wr_en, wr_data.
  - Outputs: value, wrap pulse.
REQ-023 Decode, handshake and status registers SHALL live in the top.

Verification
REQ-024 Reset, write 12'h320=0 and 12'h323=2, pulse evt_i[2] for 10 cycles -> read 12'hB03 returns 10.
REQ-025 CNT_WIDTH=8: write 12'hB03=8'hFE, two events -> counter 0, ovf[0]=1; with irq_en[0]=1, ovf_irq_o=1 one cycle later; write 12'hDA0=1 -> ovf_irq_o=0.
REQ-026 Write 12'hB03=100 in the same cycle as an event -> the response returns the old value, and the counter reads 100.
REQ-027 Hold csr_resp_ready_i=0 for 3 cycles with valid requests queued -> csr_req_ready_o=0 and rdata stable; release -> the next response follows one cycle later.
REQ-028 Access 12'hB0F with NUM_CNT=8 -> csr_excp_o=1, rdata=0, and no register changes.
REQ-029 Assert rst while a counter is running -> all outputs are 0 immediately, and inhibit reads all-ones.
